axi4_wr_arbiter: RTL and testbench
==================================

# axi4_wr_arbiter

Two-master to one-slave AXI4 write-path arbiter (AW, W and B channels) for the bus-fabric bridge. It sits between two AXI4 write masters and a single downstream AXI4 slave port. It grants one complete write burst at a time using round-robin priority. It widens the ID by one bit to encode the originating master, and routes the B response back on that bit.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, write data width; strobe width is DATA_W/8
- ID_W, 4, upstream ID width; downstream ID width is ID_W+1
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- sN_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion/awvalid  in  ID_W/ADDR_W/8/3/2/1/4/3/4/4/1  master N (N=0,1) write-address bundle
- sN_awready  out  1  master N address accept
- sN_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  master N write-data bundle
- sN_wready  out  1  master N data accept
- sN_bid/bresp/bvalid  out  ID_W/2/1  master N write response
- sN_bready  in  1  master N response accept
- m_awid  out  ID_W+1  {grant index, granted awid}
- m_awaddr..m_awregion, m_awvalid  out  same widths as sN  forwarded address bundle
- m_awready  in  1  slave address accept
- m_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  forwarded data
- m_wready  in  1  slave data accept
- m_bid/bresp/bvalid  in  ID_W+1/2/1  slave response
- m_bready  out  1  forwarded response accept
- busy  out  1  state != IDLE
- grant  out  1  index of the granted master; valid while busy
- wlast_err  out  1  one-cycle pulse on a W beat whose sN_wlast disagrees with the beat count

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
  - Only one burst is in flight at a time.
  - A new grant is issued only after the previous B handshake.
- **IDLE**
  - If any sN_awvalid=1, register grant and go to ADDR.
  - Both requesting: grant the master that is not rr_last. rr_last resets to 1, so s0 wins first.
  - Single requester: grant it.
- **ADDR**
  - m_aw* = granted sN_aw*; m_awid = {grant, sN_awid}; granted sN_awready = m_awready.
  - On m_awvalid&&m_awready: load beat_cnt = awlen, go to DATA.
- **DATA**
  - m_wdata/wstrb/wvalid from the granted master; granted sN_wready = m_wready.
  - m_wlast is driven by the arbiter as (beat_cnt==0), not by the master.
  - Each W handshake decrements beat_cnt. The handshake with beat_cnt==0 goes to RESP.
  - wlast_err pulses on any W handshake where sN_wlast != (beat_cnt==0). The burst still completes on the count.
- **RESP**
  - m_bready = sN_bready of master m_bid[ID_W].
  - That master receives bvalid=m_bvalid, bid=m_bid[ID_W-1:0] and bresp.
  - On handshake: rr_last = grant, go to IDLE.
- All ready/valid outputs toward the non-granted master, and every output in a channel whose phase is inactive, are 0.
- beat_cnt is 8 bits. awlen=255 gives 256 beats; no wrap occurs.

## Timing
- Reset:
  - state=IDLE, rr_last=1, beat_cnt=0, grant=0.
  - busy, wlast_err, all sN_awready/wready/bvalid and m_awvalid/wvalid/bready are 0.
- areset mid-burst returns to IDLE next edge and drops every valid/ready, with no completion of the burst.
- Arbitration latency: awvalid sampled in IDLE at edge k; m_awvalid=1 during cycle k+1.
- Address/data/response paths through the arbiter are combinational (zero added latency) once in the phase.
- Minimum burst of awlen beats with zero slave stalls: 1 (IDLE) + 1 (ADDR) + awlen+1 (DATA) + 1 (RESP) cycles.
- W presented before AW is held off (wready=0) until DATA; this is legal AXI slave behaviour.
- Non-granted master's awvalid is ignored and must persist. Its request is served in the next IDLE.
- Simultaneous requests in IDLE resolve strictly by rr_last; no starvation.

## Test plan
- After reset: s0 and s1 raise awvalid in the same cycle, each awlen=0.
  -> s0 granted first with m_awid={0,id}, then s1 with m_awid={1,id}; busy drops between the two bursts.
- s0 burst awlen=3 with m_wready toggling 1,0,1,0.
  -> exactly 4 W handshakes, m_wlast only on the 4th, then RESP.
- s0 sends awlen=1 but asserts wlast on beat 0.
  -> wlast_err pulses once, both beats are forwarded, and m_wlast is on beat 1.
- Slave returns m_bid=5'h1A, bresp=2'b10.
  -> s1_bvalid=1, s1_bid=4'hA, s1_bresp=2'b10; s0_bvalid stays 0.
- areset asserted mid-DATA of an awlen=7 burst.
  -> the following cycle has all valids/readys 0 and busy=0, and s0 wins the next simultaneous request.
- s1 requests continuously and s0 requests once.
  -> grants alternate s1, s0, s1; s0 waits at most one burst.

Source files
------------

// File: rtl/axi4_wr_arbiter.sv
// rtl/axi4_wr_arbiter.sv - two-master to one-slave AXI4 write arbiter, one burst in flight
// Round-robin grant per burst; downstream ID carries the grant index in its MSB.
module axi4_wr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [ID_W-1:0]     s0_awid,
   input  logic [ADDR_W-1:0]   s0_awaddr,
   input  logic [7:0]          s0_awlen,
   input  logic [2:0]          s0_awsize,
   input  logic [1:0]          s0_awburst,
   input  logic                s0_awlock,
   input  logic [3:0]          s0_awcache,
   input  logic [2:0]          s0_awprot,
   input  logic [3:0]          s0_awqos,
   input  logic [3:0]          s0_awregion,
   input  logic                s0_awvalid,
   output logic                s0_awready,
   input  logic [DATA_W-1:0]   s0_wdata,
   input  logic [DATA_W/8-1:0] s0_wstrb,
   input  logic                s0_wlast,
   input  logic                s0_wvalid,
   output logic                s0_wready,
   output logic [ID_W-1:0]     s0_bid,
   output logic [1:0]          s0_bresp,
   output logic                s0_bvalid,
   input  logic                s0_bready,
   input  logic [ID_W-1:0]     s1_awid,
   input  logic [ADDR_W-1:0]   s1_awaddr,
   input  logic [7:0]          s1_awlen,
   input  logic [2:0]          s1_awsize,
   input  logic [1:0]          s1_awburst,
   input  logic                s1_awlock,
   input  logic [3:0]          s1_awcache,
   input  logic [2:0]          s1_awprot,
   input  logic [3:0]          s1_awqos,
   input  logic [3:0]          s1_awregion,
   input  logic                s1_awvalid,
   output logic                s1_awready,
   input  logic [DATA_W-1:0]   s1_wdata,
   input  logic [DATA_W/8-1:0] s1_wstrb,
   input  logic                s1_wlast,
   input  logic                s1_wvalid,
   output logic                s1_wready,
   output logic [ID_W-1:0]     s1_bid,
   output logic [1:0]          s1_bresp,
   output logic                s1_bvalid,
   input  logic                s1_bready,
   output logic [ID_W:0]       m_awid,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [7:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [1:0]          m_awburst,
   output logic                m_awlock,
   output logic [3:0]          m_awcache,
   output logic [2:0]          m_awprot,
   output logic [3:0]          m_awqos,
   output logic [3:0]          m_awregion,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [ID_W:0]       m_bid,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic                busy,
   output logic                grant,
   output logic                wlast_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t     state_q, state_d;
   logic       grant_q, grant_d;
   logic       rr_last_q, rr_last_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;

   logic g_awvalid, g_wvalid, g_wlast, last_beat, b_sel;

   assign g_awvalid = grant_q ? s1_awvalid : s0_awvalid;
   assign g_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
   assign g_wlast   = grant_q ? s1_wlast   : s0_wlast;
   assign last_beat = (beat_cnt_q == 8'd0);
   assign b_sel     = m_bid[ID_W];
   assign busy      = (state_q != IDLE);
   assign grant     = grant_q;

   // Each channel is forwarded only during its own phase; everything else is held at 0.
   always_comb begin
      m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
      m_awlock = 1'b0; m_awcache = '0; m_awprot = '0; m_awqos = '0; m_awregion = '0;
      m_awvalid = 1'b0; s0_awready = 1'b0; s1_awready = 1'b0;
      m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
      s0_wready = 1'b0; s1_wready = 1'b0; wlast_err = 1'b0;
      m_bready = 1'b0; s0_bvalid = 1'b0; s1_bvalid = 1'b0;
      s0_bid = '0; s1_bid = '0; s0_bresp = '0; s1_bresp = '0;
      case (state_q)
         ADDR: begin
            m_awid     = grant_q ? {1'b1, s1_awid} : {1'b0, s0_awid};
            m_awaddr   = grant_q ? s1_awaddr   : s0_awaddr;
            m_awlen    = grant_q ? s1_awlen    : s0_awlen;
            m_awsize   = grant_q ? s1_awsize   : s0_awsize;
            m_awburst  = grant_q ? s1_awburst  : s0_awburst;
            m_awlock   = grant_q ? s1_awlock   : s0_awlock;
            m_awcache  = grant_q ? s1_awcache  : s0_awcache;
            m_awprot   = grant_q ? s1_awprot   : s0_awprot;
            m_awqos    = grant_q ? s1_awqos    : s0_awqos;
            m_awregion = grant_q ? s1_awregion : s0_awregion;
            m_awvalid  = g_awvalid;
            s0_awready = !grant_q && m_awready;
            s1_awready = grant_q && m_awready;
         end
         DATA: begin
            m_wdata   = grant_q ? s1_wdata : s0_wdata;
            m_wstrb   = grant_q ? s1_wstrb : s0_wstrb;
            m_wlast   = last_beat;
            m_wvalid  = g_wvalid;
            s0_wready = !grant_q && m_wready;
            s1_wready = grant_q && m_wready;
            wlast_err = g_wvalid && m_wready && (g_wlast != last_beat);
         end
         RESP: begin
            m_bready = b_sel ? s1_bready : s0_bready;
            if (b_sel) begin
               s1_bvalid = m_bvalid;
               s1_bid    = m_bid[ID_W-1:0];
               s1_bresp  = m_bresp;
            end else begin
               s0_bvalid = m_bvalid;
               s0_bid    = m_bid[ID_W-1:0];
               s0_bresp  = m_bresp;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_last_d  = rr_last_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: if (s0_awvalid || s1_awvalid) begin
            grant_d = (s0_awvalid && s1_awvalid) ? !rr_last_q : s1_awvalid;
            state_d = ADDR;
         end
         ADDR: if (g_awvalid && m_awready) begin
            beat_cnt_d = grant_q ? s1_awlen : s0_awlen;
            state_d    = DATA;
         end
         DATA: if (g_wvalid && m_wready) begin
            // Burst length is governed by the count, never by the master's wlast.
            if (last_beat) state_d = RESP;
            else           beat_cnt_d = beat_cnt_q - 8'd1;
         end
         RESP: if (m_bvalid && m_bready) begin
            rr_last_d = grant_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         rr_last_q  <= 1'b1;
         beat_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_last_q  <= rr_last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// tb/tb_axi4_wr_arbiter.sv - directed self-checking bench for axi4_wr_arbiter
module tb_axi4_wr_arbiter;

   logic        aclk, areset;
   logic [3:0]  s0_awid, s1_awid;
   logic [31:0] s0_awaddr, s1_awaddr;
   logic [7:0]  s0_awlen, s1_awlen;
   logic [2:0]  s0_awsize, s1_awsize, s0_awprot, s1_awprot;
   logic [1:0]  s0_awburst, s1_awburst;
   logic        s0_awlock, s1_awlock;
   logic [3:0]  s0_awcache, s1_awcache, s0_awqos, s1_awqos, s0_awregion, s1_awregion;
   logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready;
   logic [31:0] s0_wdata, s1_wdata;
   logic [3:0]  s0_wstrb, s1_wstrb;
   logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
   logic [3:0]  s0_bid, s1_bid;
   logic [1:0]  s0_bresp, s1_bresp;
   logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
   logic [4:0]  m_awid;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize, m_awprot;
   logic [1:0]  m_awburst;
   logic        m_awlock;
   logic [3:0]  m_awcache, m_awqos, m_awregion;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wlast, m_wvalid, m_wready;
   logic [4:0]  m_bid;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready;
   logic        busy, grant, wlast_err;

   int n_assert = 0;
   int n_fail   = 0;

   axi4_wr_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
      .aclk(aclk), .areset(areset),
      .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
      .s0_awburst(s0_awburst), .s0_awlock(s0_awlock), .s0_awcache(s0_awcache),
      .s0_awprot(s0_awprot), .s0_awqos(s0_awqos), .s0_awregion(s0_awregion),
      .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
      .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
      .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
      .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
      .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
      .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache),
      .s1_awprot(s1_awprot), .s1_awqos(s1_awqos), .s1_awregion(s1_awregion),
      .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
      .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
      .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
      .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
      .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awregion(m_awregion),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .busy(busy), .grant(grant), .wlast_err(wlast_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Address phase from IDLE: one cycle to grant, one to handshake; granted master then drops awvalid.
   task automatic aw_phase(input logic g, input logic keep_s1);
      tick();
      m_awready = 1'b1;
      tick();
      m_awready = 1'b0;
      if (!g) s0_awvalid = 1'b0;
      else if (!keep_s1) s1_awvalid = 1'b0;
   endtask

   // Single-beat burst from IDLE with the expected grant supplied by the caller.
   task automatic do_burst(input string tag, input logic g, input logic keep_s1,
                           input logic [4:0] bid, input logic [1:0] bresp);
      logic [4:0] exp_id;
      exp_id = g ? {1'b1, s1_awid} : {1'b0, s0_awid};
      tick();
      chk({tag, "_grant"}, grant, g);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_m_awvalid"}, m_awvalid, 1'b1);
      chk({tag, "_m_awid"}, m_awid, exp_id);
      m_awready = 1'b1;
      #1;
      chk({tag, "_awready"}, {s1_awready, s0_awready}, g ? 2'b10 : 2'b01);
      tick();
      m_awready = 1'b0;
      if (!g) s0_awvalid = 1'b0;
      else if (!keep_s1) s1_awvalid = 1'b0;
      if (g) begin s1_wvalid = 1'b1; s1_wdata = 32'hD1; s1_wlast = 1'b1; end
      else   begin s0_wvalid = 1'b1; s0_wdata = 32'hD0; s0_wlast = 1'b1; end
      m_wready = 1'b1;
      #1;
      chk({tag, "_m_wdata"}, m_wdata, g ? 32'hD1 : 32'hD0);
      chk({tag, "_m_wlast"}, m_wlast, 1'b1);
      chk({tag, "_wready"}, {s1_wready, s0_wready}, g ? 2'b10 : 2'b01);
      tick();
      s0_wvalid = 1'b0; s1_wvalid = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; m_bid = bid; m_bresp = bresp;
      #1;
      chk({tag, "_bvalid"}, {s1_bvalid, s0_bvalid}, bid[4] ? 2'b10 : 2'b01);
      chk({tag, "_bid"}, bid[4] ? s1_bid : s0_bid, bid[3:0]);
      chk({tag, "_bresp"}, bid[4] ? s1_bresp : s0_bresp, bresp);
      chk({tag, "_m_bready"}, m_bready, 1'b1);
      tick();
      m_bvalid = 1'b0;
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int hs;
      int b;
      areset = 1'b1;
      {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache,
       s0_awprot, s0_awqos, s0_awregion, s0_awvalid} = '0;
      {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache,
       s1_awprot, s1_awqos, s1_awregion, s1_awvalid} = '0;
      {s0_wdata, s0_wstrb, s0_wlast, s0_wvalid, s0_bready} = '0;
      {s1_wdata, s1_wstrb, s1_wlast, s1_wvalid, s1_bready} = '0;
      {m_awready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
      s0_bready = 1'b1; s1_bready = 1'b1;
      s0_wstrb = 4'hF; s1_wstrb = 4'hF;
      repeat (2) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, 1'b0);
      chk("rst_wlast_err", wlast_err, 1'b0);
      chk("rst_valids", {m_awvalid, m_wvalid, m_bready, s0_awready, s1_awready,
                         s0_wready, s1_wready, s0_bvalid, s1_bvalid}, 9'h0);
      areset = 1'b0;

      // Simultaneous requests after reset: s0 first, then s1 with slave bid 1A.
      s0_awid = 4'h3; s0_awaddr = 32'h1000; s0_awvalid = 1'b1;
      s1_awid = 4'h5; s1_awaddr = 32'h2000; s1_awvalid = 1'b1;
      #1;
      chk("idle_no_awvalid", m_awvalid, 1'b0);
      do_burst("sim_s0", 1'b0, 1'b0, 5'h03, 2'b00);
      do_burst("sim_s1", 1'b1, 1'b0, 5'h1A, 2'b10);

      // s0 awlen=3 burst with slave wready toggling every cycle.
      s0_awlen = 8'd3; s0_awvalid = 1'b1;
      aw_phase(1'b0, 1'b0);
      chk("len3_in_data", busy, 1'b1);
      hs = 0; b = 0;
      for (int c = 0; c < 7; c++) begin
         s0_wvalid = 1'b1; s0_wdata = 32'hA0 + b; s0_wlast = (c >= 5);
         m_wready = (c % 2 == 0);
         #1;
         chk("len3_m_wlast", m_wlast, (c >= 5));
         chk("len3_wlast_err", wlast_err, 1'b0);
         if (m_wvalid && m_wready) begin
            chk("len3_wdata", m_wdata, 32'hA0 + b);
            hs++; b++;
         end
         tick();
      end
      chk("len3_hs_count", hs, 4);
      s0_wvalid = 1'b0; m_wready = 1'b0;
      #1;
      chk("len3_resp_wvalid", {m_wvalid, s0_wready}, 2'b00);
      m_bvalid = 1'b1; m_bid = 5'h00;
      #1;
      chk("len3_bvalid", s0_bvalid, 1'b1);
      tick();
      m_bvalid = 1'b0;
      chk("len3_idle", busy, 1'b0);

      // awlen=1 with early wlast on beat 0.
      s0_awlen = 8'd1; s0_awvalid = 1'b1;
      aw_phase(1'b0, 1'b0);
      s0_wvalid = 1'b1; s0_wdata = 32'hB0; s0_wlast = 1'b1; m_wready = 1'b1;
      #1;
      chk("early_err_b0", wlast_err, 1'b1);
      chk("early_m_wlast_b0", m_wlast, 1'b0);
      chk("early_wdata_b0", {m_wvalid, m_wdata}, {1'b1, 32'hB0});
      tick();
      s0_wdata = 32'hB1;
      #1;
      chk("early_err_b1", wlast_err, 1'b0);
      chk("early_m_wlast_b1", m_wlast, 1'b1);
      chk("early_wdata_b1", {m_wvalid, m_wdata}, {1'b1, 32'hB1});
      tick();
      s0_wvalid = 1'b0; m_wready = 1'b0;
      chk("early_resp_busy", busy, 1'b1);
      chk("early_resp_err", wlast_err, 1'b0);
      m_bvalid = 1'b1; m_bid = 5'h00;
      tick();
      m_bvalid = 1'b0;

      // Reset during the DATA phase of an awlen=7 burst (last grant was s0).
      s0_awlen = 8'd7; s0_awvalid = 1'b1;
      aw_phase(1'b0, 1'b0);
      s0_wvalid = 1'b1; s0_wlast = 1'b0; m_wready = 1'b1;
      repeat (2) tick();
      areset = 1'b1;
      tick();
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valids", {m_awvalid, m_wvalid, m_bready, s0_awready, s1_awready,
                             s0_wready, s1_wready, s0_bvalid, s1_bvalid}, 9'h0);
      areset = 1'b0; s0_wvalid = 1'b0; m_wready = 1'b0;
      s0_awlen = 8'd0; s1_awlen = 8'd0;
      s0_awvalid = 1'b1; s1_awvalid = 1'b1;
      do_burst("post_rst_s0", 1'b0, 1'b1, 5'h03, 2'b00);

      // s1 requests continuously; s0 requests once.
      do_burst("cont_s1a", 1'b1, 1'b1, 5'h15, 2'b00);
      s0_awvalid = 1'b1;
      do_burst("cont_s0", 1'b0, 1'b1, 5'h03, 2'b01);
      do_burst("cont_s1b", 1'b1, 1'b0, 5'h15, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
